serial_subtractor: RTL and testbench

- Multi-cycle signed/unsigned subtractor. Computes f = a - b over WIDTH/DIGIT_W clock cycles using two's-complement addition (a + ~b + 1), one DIGIT_W-bit digit per cycle, LSB digit first.
- Reports signed overflow and unsigned borrow.
- Sits beside the combinational 16-bit adder in the Lab datapath. It is the inverse operation, trading area for latency, and uses a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 32 +++
 rtl/digit_subtractor.sv | 32 +++
 rtl/serial_subtractor.sv | 163 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the digit-serial subtractor.
//                - state_t       : controller state encoding (IDLE/RUN/DONE)
//                - DEF_WIDTH     : default operand width
//                - DEF_DIGIT_W   : default digit width (bits per cycle)
//                - digit_idx_w() : width of the digit-index counter
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index N = width/digit_w digits. A single-digit
    // configuration still gets a 1-bit counter so the vector is never empty.
    function automatic int digit_idx_w(input int width, input int digit_w);
        int n;
        n = width / digit_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : digit_subtractor
//  Description : Combinational DIGIT_W-bit subtract slice computing
//                {o_carry, o_diff} = i_a + ~i_b + i_carry.
//                A carry of 1 out of the slice means "no borrow".
//  Ports       : i_a     [DIGIT_W] minuend digit
//                i_b     [DIGIT_W] subtrahend digit
//                i_carry [1]       carry in (1 for the least significant digit)
//                o_diff  [DIGIT_W] difference digit
//                o_carry [1]       carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_subtractor #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_carry,
    output logic [DIGIT_W-1:0] o_diff,
    output logic               o_carry
);

    logic [DIGIT_W:0] w_sum;

    assign w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + {{DIGIT_W{1'b0}}, i_carry};
    assign o_diff  = w_sum[DIGIT_W-1:0];
    assign o_carry = w_sum[DIGIT_W];

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Digit-serial subtractor, f = a - b, one DIGIT_W-bit digit per
//                clock, least significant digit first. Reports signed
//                overflow and unsigned borrow. start/done handshake; a new
//                operation may be accepted in IDLE or on the DONE cycle.
//  Ports       : clk    [1]     rising-edge clock
//                rst    [1]     synchronous active-high reset
//                start  [1]     request; sampled only in IDLE or DONE
//                a      [WIDTH] minuend, captured on the accepted start edge
//                b      [WIDTH] subtrahend, captured on the accepted start edge
//                busy   [1]     high while the operation is in progress
//                done   [1]     one-cycle pulse, result valid
//                f      [WIDTH] result (held until the next completion)
//                ovf    [1]     signed overflow of a - b
//                borrow [1]     unsigned borrow (a < b)
//  Options     : SERIAL_SUB_SATURATE_EN - when defined, f is clamped to the
//                signed extreme on overflow (0x7FF..F if a >= 0, else
//                0x800..0). Flags are unaffected.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             borrow
);

    localparam int c_N_DIGITS = WIDTH / DIGIT_W;
    localparam int c_KW       = digit_idx_w(WIDTH, DIGIT_W);
    localparam logic [c_KW-1:0] c_LAST_K = c_KW'(c_N_DIGITS - 1);

    // Configuration guard: the digit width must tile the operand exactly.
    generate
        if ((WIDTH % DIGIT_W) != 0) begin : g_param_check
            $error("serial_subtractor: DIGIT_W must divide WIDTH");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_KW-1:0]    r_k;

    logic [DIGIT_W-1:0] w_a_dig;
    logic [DIGIT_W-1:0] w_b_dig;
    logic [DIGIT_W-1:0] w_diff;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_f_final;
    logic               w_ovf;
    logic               w_last;
    logic               w_accept;

    // ------------------------------------------------------------------
    // Digit datapath: select digit k of each latched operand, subtract it
    // in the single shared slice, and merge the result digit back.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_dig    = r_a[int'(r_k) * DIGIT_W +: DIGIT_W];
        w_b_dig    = r_b[int'(r_k) * DIGIT_W +: DIGIT_W];
        w_res_next = r_res;
        w_res_next[int'(r_k) * DIGIT_W +: DIGIT_W] = w_diff;
    end

    digit_subtractor #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_a     (w_a_dig),
        .i_b     (w_b_dig),
        .i_carry (r_carry),
        .o_diff  (w_diff),
        .o_carry (w_cout)
    );

    // Overflow only possible when the operand signs differ; then the result
    // must carry the sign of a, otherwise it wrapped.
    assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                   (w_res_next[WIDTH-1] != r_a[WIDTH-1]);

`ifdef SERIAL_SUB_SATURATE_EN
    always_comb begin
        w_f_final = w_res_next;
        if (w_ovf) begin
            w_f_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_f_final = w_res_next;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    assign w_last   = (r_k == c_LAST_K);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            f       <= '0;
            ovf     <= 1'b0;
            borrow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_res   <= '0;
                // Carry-in of 1 supplies the "+1" of the two's complement.
                r_carry <= 1'b1;
                r_k     <= '0;
            end else if (r_state == RUN) begin
                r_res   <= w_res_next;
                r_carry <= w_cout;
                r_k     <= w_last ? '0 : r_k + c_KW'(1);
                // Visible outputs only move on the edge that enters DONE.
                if (w_last) begin
                    f      <= w_f_final;
                    ovf    <= w_ovf;
                    borrow <= ~w_cout;
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (16-bit, 4-bit
//                digits). An arithmetic reference model predicts busy, done,
//                f, ovf and borrow every cycle; directed operations check
//                hand-computed results and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int N = 4;

`ifdef SERIAL_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] f;
    logic        ovf;
    logic        borrow;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(
        .WIDTH   (16),
        .DIGIT_W (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .f      (f),
        .ovf    (ovf),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic: {f, ovf, borrow}.
    function automatic logic [17:0] model_sub(input logic [15:0] x, input logic [15:0] y);
        int          sd;
        logic [15:0] r;
        logic        o;
        logic        br;
        sd = int'($signed(x)) - int'($signed(y));
        r  = x - y;
        o  = (sd > 32767) || (sd < -32768);
        br = (x < y);
        if (SAT && o) r = (sd < 0) ? 16'h8000 : 16'h7FFF;
        return {r, o, br};
    endfunction

    // Model: phase 0 idle, 1..N operation in progress, N+1 result cycle.
    int          m_phase = 0;
    logic [17:0] m_pend  = '0;
    logic [15:0] m_f     = '0;
    logic        m_ovf   = 1'b0;
    logic        m_borrow = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_pend   <= '0;
            m_f      <= '0;
            m_ovf    <= 1'b0;
            m_borrow <= 1'b0;
        end else if ((m_phase == 0 || m_phase == N + 1) && start) begin
            m_phase <= 1;
            m_pend  <= model_sub(a, b);
        end else if (m_phase >= 1 && m_phase < N) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == N) begin
            m_phase <= N + 1;
            {m_f, m_ovf, m_borrow} <= m_pend;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",   32'(busy),   32'(m_phase >= 1 && m_phase <= N));
        chk("cyc_done",   32'(done),   32'(m_phase == N + 1));
        chk("cyc_f",      32'(f),      32'(m_f));
        chk("cyc_ovf",    32'(ovf),    32'(m_ovf));
        chk("cyc_borrow", 32'(borrow), 32'(m_borrow));
    end

    // Drive one start pulse; returns at the negedge after the sampling edge.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string nm, input int lat, input logic [15:0] ef,
                                input logic eo, input logic eb);
        chk({nm, "_latency"}, 32'(lat),    32'(5));
        chk({nm, "_f"},       32'(f),      32'(ef));
        chk({nm, "_ovf"},     32'(ovf),    32'(eo));
        chk({nm, "_borrow"},  32'(borrow), 32'(eb));
    endtask

    task automatic run_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] ef, input logic eo, input logic eb);
        int lat;
        start_op(x, y);
        wait_done(1, lat);
        check_result(nm, lat, ef, eo, eb);
    endtask

    initial begin
        int lat;
        int n_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;

        // Model pins against hand-computed values.
        chk("pin_5_3",     32'(model_sub(16'h0005, 16'h0003)), 32'({16'h0002, 1'b0, 1'b0}));
        chk("pin_0_1",     32'(model_sub(16'h0000, 16'h0001)), 32'({16'hFFFF, 1'b0, 1'b1}));
        chk("pin_8000_1",  32'(model_sub(16'h8000, 16'h0001)),
            32'({SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0}));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_f",      32'(f),      32'(0));
        chk("reset_ovf",    32'(ovf),    32'(0));
        chk("reset_borrow", 32'(borrow), 32'(0));
        chk("reset_busy",   32'(busy),   32'(0));
        chk("reset_done",   32'(done),   32'(0));

        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("idle_no_done", 32'(n_done), 32'(0));

        run_op("sub_5_3",        16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_op("sub_8000_1",     16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0);
        run_op("sub_7fff_ffff",  16'h7FFF, 16'hFFFF, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b1);

        // Back-to-back: restart on the done cycle.
        start_op(16'h0000, 16'h0001);
        wait_done(1, lat);
        check_result("sub_0_1", lat, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b1; a = 16'h1234; b = 16'h1234;
        @(negedge clk);
        start = 1'b0; a = 16'hAAAA; b = 16'h5555;
        wait_done(1, lat);
        check_result("b2b_equal", lat, 16'h0000, 1'b0, 1'b0);

        // Start while busy is ignored.
        start_op(16'h00FF, 16'h000F);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        check_result("ignore_restart", lat, 16'h00F0, 1'b0, 1'b0);

        // Reset in the middle of an operation.
        start_op(16'h1234, 16'h0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_f",      32'(f),      32'(0));
        chk("abort_ovf",    32'(ovf),    32'(0));
        chk("abort_borrow", 32'(borrow), 32'(0));
        chk("abort_busy",   32'(busy),   32'(0));
        chk("abort_done",   32'(done),   32'(0));
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'(0));

        run_op("after_abort", 16'h0010, 16'h0020, 16'hFFF0, 1'b0, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
